// File: rtl/logic_processor.sv
// Bit-serial logic processor: two operand registers shifted right together,
// LSBs combined by a selectable logic function and routed back into the MSBs.
module logic_processor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic [6:0]       AhexU,
    output logic [6:0]       AhexL,
    output logic [6:0]       BhexU,
    output logic [6:0]       BhexL
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // The per-step states S1..S8 collapse into SHIFT plus a step counter.
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lda_s, ldb_s, exe_s;
    logic [WIDTH-1:0] a_q, b_q;
    logic          f_bit, new_a, new_b;
    logic [7:0]    a8, b8;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lda_s <= 1'b1;
            ldb_s <= 1'b1;
            exe_s <= 1'b1;
        end else begin
            lda_s <= LoadA;
            ldb_s <= LoadB;
            exe_s <= Execute;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!exe_s) state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = HOLD;
            end
            HOLD: begin
                if (exe_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        f_bit = 1'b0;
        case (F)
            3'b000: f_bit = a_q[0] & b_q[0];
            3'b001: f_bit = a_q[0] | b_q[0];
            3'b010: f_bit = a_q[0] ^ b_q[0];
            3'b011: f_bit = 1'b1;
            3'b100: f_bit = ~(a_q[0] & b_q[0]);
            3'b101: f_bit = ~(a_q[0] | b_q[0]);
            3'b110: f_bit = ~(a_q[0] ^ b_q[0]);
            default: f_bit = 1'b0;
        endcase
    end

    always_comb begin
        new_a = a_q[0];
        new_b = b_q[0];
        case (R)
            2'b01: new_b = f_bit;
            2'b10: new_a = f_bit;
            2'b11: begin
                new_a = b_q[0];
                new_b = a_q[0];
            end
            default: ;
        endcase
    end

    // Loads share the IDLE cycle that first sees Execute, so the op uses the new value.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state_q == IDLE) begin
            if (!lda_s) a_q <= Din;
            if (!ldb_s) b_q <= Din;
        end else if (state_q == SHIFT) begin
            a_q <= {new_a, a_q[WIDTH-1:1]};
            b_q <= {new_b, b_q[WIDTH-1:1]};
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign a8    = 8'(a_q);
    assign b8    = 8'(b_q);
    assign Aval  = a_q;
    assign Bval  = b_q;
    assign AhexU = hex7(a8[7:4]);
    assign AhexL = hex7(a8[3:0]);
    assign BhexU = hex7(b8[7:4]);
    assign BhexL = hex7(b8[3:0]);

endmodule

// File: tb/tb_logic_processor.sv
// Scoreboard bench for logic_processor: expected register values are queued
// when an operation is launched and compared once it has had time to finish.
module tb_logic_processor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       LoadA = 1'b1;
    logic       LoadB = 1'b1;
    logic       Execute = 1'b1;
    logic [7:0] Din = '0;
    logic [2:0] F = '0;
    logic [1:0] R = '0;
    logic [7:0] Aval, Bval;
    logic [6:0] AhexU, AhexL, BhexU, BhexL;

    logic_processor #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB),
        .Execute(Execute), .Din(Din), .F(F), .R(R),
        .Aval(Aval), .Bval(Bval),
        .AhexU(AhexU), .AhexL(AhexL), .BhexU(BhexU), .BhexL(BhexL)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [7:0] ma = '0, mb = '0;

    logic [6:0] seg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_hex(input string tag, input logic [7:0] a, input logic [7:0] b);
        check({tag, "_AhexU"}, 32'(AhexU), 32'(seg[a[7:4]]));
        check({tag, "_AhexL"}, 32'(AhexL), 32'(seg[a[3:0]]));
        check({tag, "_BhexU"}, 32'(BhexU), 32'(seg[b[7:4]]));
        check({tag, "_BhexL"}, 32'(BhexL), 32'(seg[b[3:0]]));
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_A"}, 32'(Aval), 32'(e.a));
            check({e.tag, "_B"}, 32'(Bval), 32'(e.b));
            check_hex(e.tag, e.a, e.b);
        end
    endtask

    // Whole-byte reference: the serial datapath must equal the bitwise result.
    task automatic model(input logic [2:0] f, input logic [1:0] r);
        logic [7:0] res;
        case (f)
            3'd0: res = ma & mb;
            3'd1: res = ma | mb;
            3'd2: res = ma ^ mb;
            3'd3: res = 8'hFF;
            3'd4: res = ~(ma & mb);
            3'd5: res = ~(ma | mb);
            3'd6: res = ~(ma ^ mb);
            default: res = 8'h00;
        endcase
        case (r)
            2'd1: mb = res;
            2'd2: ma = res;
            2'd3: {ma, mb} = {mb, ma};
            default: ;
        endcase
    endtask

    task automatic load(input logic la, input logic lb, input logic [7:0] v);
        Din = v;
        LoadA = ~la;
        LoadB = ~lb;
        tick();
        LoadA = 1'b1;
        LoadB = 1'b1;
        repeat (2) tick();
        if (la) ma = v;
        if (lb) mb = v;
    endtask

    task automatic launch(input logic [2:0] f, input logic [1:0] r, input int unsigned hold,
                          input string tag, input logic [7:0] ea, input logic [7:0] eb);
        F = f;
        R = r;
        sb.push_back('{tag, ea, eb});
        Execute = 1'b0;
        repeat (hold) tick();
        Execute = 1'b1;
        repeat (12) tick();
        pop_check();
    endtask

    task automatic run_op(input logic [2:0] f, input logic [1:0] r, input int unsigned hold,
                          input string tag);
        model(f, r);
        launch(f, r, hold, tag, ma, mb);
    endtask

    logic [7:0] sweep [8] = '{8'hC0, 8'hFC, 8'h3C, 8'hFF, 8'h3F, 8'h03, 8'hC3, 8'h00};

    initial begin
        #12;
        check("reset_A", 32'(Aval), 32'h00);
        check("reset_B", 32'(Bval), 32'h00);
        check_hex("reset", 8'h00, 8'h00);
        Reset = 1'b1;
        repeat (2) tick();

        load(1'b1, 1'b0, 8'h33);
        load(1'b0, 1'b1, 8'h55);
        check("load_A", 32'(Aval), 32'h33);
        check("load_B", 32'(Bval), 32'h55);

        run_op(3'b010, 2'b10, 11, "xor_long_hold");
        run_op(3'b110, 2'b01, 1, "xnor_pulse");
        run_op(3'b000, 2'b11, 1, "swap");
        run_op(3'b001, 2'b00, 1, "keep");

        load(1'b0, 1'b1, 8'hCC);
        for (int i = 0; i < 8; i++) begin
            load(1'b1, 1'b0, 8'hF0);
            ma = sweep[i];
            launch(3'(i), 2'b10, 1, $sformatf("sweep_f%0d", i), sweep[i], 8'hCC);
        end

        // LoadA arriving mid-shift must be ignored.
        load(1'b1, 1'b1, 8'h5A);
        model(3'b010, 2'b01);
        sb.push_back('{"load_ignored", ma, mb});
        F = 3'b010;
        R = 2'b01;
        Execute = 1'b0;
        tick();
        Execute = 1'b1;
        repeat (3) tick();
        Din = 8'hAA;
        LoadA = 1'b0;
        repeat (2) tick();
        LoadA = 1'b1;
        repeat (10) tick();
        pop_check();

        // Reset during S4 aborts the operation.
        load(1'b1, 1'b1, 8'h96);
        F = 3'b011;
        R = 2'b10;
        Execute = 1'b0;
        tick();
        Execute = 1'b1;
        repeat (4) tick();
        Reset = 1'b0;
        #1;
        check("abort_A", 32'(Aval), 32'h00);
        check("abort_B", 32'(Bval), 32'h00);
        ma = '0;
        mb = '0;
        tick();
        Reset = 1'b1;
        repeat (12) tick();
        check("abort_idle_A", 32'(Aval), 32'h00);

        load(1'b1, 1'b0, 8'h3C);
        load(1'b0, 1'b1, 8'h0F);
        check("post_reset_load_A", 32'(Aval), 32'h3C);
        run_op(3'b000, 2'b10, 1, "post_reset_and");

        // Load seen in the same cycle as Execute is applied before shifting.
        Din = 8'hA5;
        LoadA = 1'b0;
        ma = 8'hA5;
        model(3'b001, 2'b01);
        sb.push_back('{"load_with_exec", ma, mb});
        F = 3'b001;
        R = 2'b01;
        Execute = 1'b0;
        tick();
        LoadA = 1'b1;
        Execute = 1'b1;
        repeat (12) tick();
        pop_check();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_processor.md
Name: logic_processor

Overview:
- 8-bit bit-serial logic processor with two operand registers A and B.
- Data is loaded from an 8-bit input, Din. On Execute, the block shifts both registers right for 8 cycles and combines the LSBs through a 3-bit-selected logic function. A 2-bit routing code decides where each result bit goes.
- Sits behind board pushbuttons and switches; drives value buses and four 7-segment displays.

Parameters:
- WIDTH, 8, register width and shift count (must be ≥1).

Ports:
- Clk in 1: system clock, rising-edge.
- Reset in 1: asynchronous, active-low reset.
- LoadA in 1: active-low; load Din into A.
- LoadB in 1: active-low; load Din into B.
- Execute in 1: active-low; start one operation.
- Din in 8: load data.
- F in 3: function select.
- R in 2: routing select.
- Aval out 8: register A contents.
- Bval out 8: register B contents.
- AhexU out 7: active-low segments, A[7:4].
- AhexL out 7: active-low segments, A[3:0].
- BhexU out 7: active-low segments, B[7:4].
- BhexL out 7: active-low segments, B[3:0].

Behaviour:
- Input sync: LoadA, LoadB, Execute each pass through one flip-flop before use. Din, F and R are used directly.
- Reset (async, active-low) forces:
  - A = B = 0x00.
  - Input sync flops to the deasserted value (1).
  - FSM to IDLE.
  - Hex outputs therefore show "0".
  - Reset mid-operation aborts the operation; the partial result is discarded.
- FSM states: IDLE, S1..S8 (shift), HOLD.
  - IDLE: go to S1 when synced Execute = 0.
  - S1..S8: shift A and B once per clock, then advance; S8 goes to HOLD.
  - HOLD: wait until synced Execute = 1, then return to IDLE.
  - Exactly one operation per Execute press, whether the press is held or pulsed.
- Loads are honoured only in IDLE and are synchronous.
  - LoadA and LoadB asserted together load both registers.
  - A load in the same cycle Execute is first seen in IDLE is performed; the operation then uses the new value.
  - Loads are ignored in S1..S8 and HOLD.
- Shift step in each S state:
  - f = F-function of A[0], B[0].
  - A <= {newA, A[7:1]}, B <= {newB, B[7:1]}.
  - After 8 shifts each register holds the full 8-bit routed result, because the function is bitwise.
- F encoding:
  - 000: AND.
  - 001: OR.
  - 010: XOR.
  - 011: constant 1.
  - 100: NAND.
  - 101: NOR.
  - 110: XNOR.
  - 111: constant 0.
- R encoding (newA, newB):
  - 00: (A[0], B[0]), registers unchanged.
  - 01: (A[0], f), B gets the result.
  - 10: (f, B[0]), A gets the result.
  - 11: (B[0], A[0]), swap.
- F and R are sampled every shift cycle and must be held stable during S1..S8.
- Latency: the result is complete in Aval/Bval at most 10 rising edges after Execute falls (1 sync + 1 IDLE→S1 + 8 shifts). The final value is stable in HOLD and IDLE.
- Aval/Bval are the register contents directly, so intermediate shifted values are visible during S1..S8.
- Hex decoder: combinational, active-low, bit0 = segment a … bit6 = segment g. Patterns:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000.
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011.
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110.

Test Plan:
- Reset low → Aval = Bval = 0x00, all hex outputs = 1000000. Release reset; LoadA pulse with Din = 0x33, then LoadB pulse with Din = 0x55 → Aval = 0x33, Bval = 0x55.
- F = 010, R = 10, Execute held low 11 cycles then released → Aval = 0x66, Bval = 0x55. Only one operation occurs despite the long hold.
- F = 110, R = 01, Execute pulsed for 1 cycle, wait 11 cycles → Aval = 0x66, Bval = ~(0x66 ^ 0x55) = 0xCC.
- R = 11, Execute pulsed → Aval = 0xCC, Bval = 0x66 (swap). R = 00 → values unchanged.
- Sweep F = 000..111 with A = 0xF0, B = 0xCC, R = 10 → A = 0xC0, 0xFC, 0x3C, 0xFF, 0x3F, 0x03, 0xC3, 0x00.
- Assert LoadA with Din = 0xAA during S4 → ignored. Assert Reset during S4 → A = B = 0x00, FSM in IDLE. Next Execute runs normally.
